// File: rtl/alu_input_sequencer.sv
// ALU board front end: synchronises and debounces buttons into one-cycle strobes, latches A/B/control, sequences the display page.
// Optional feature macro ALU_IN_SNAPSHOT_EN: page 2 shows f_in frozen at the moment the page is entered.
module alu_input_sequencer #(
  parameter int DB_LIMIT = 1000000,
  parameter int DB_CNT_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sw,
  input  logic [3:0]  btn,
  input  logic [31:0] f_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [3:0]  alu_op,
  output logic        cf,
  output logic        vf,
  output logic        shift_carry_out,
  output logic [31:0] disp_data,
  output logic [1:0]  page,
  output logic [3:0]  btn_pulse
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]          stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic [3:0]          pulse_q, pulse_d;
  logic [DB_CNT_W-1:0] cnt_q [4];
  logic [DB_CNT_W-1:0] cnt_d [4];
  logic [31:0]         a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [6:0]          ctl_q, ctl_d;
  logic [1:0]          page_q, page_d;
`ifdef ALU_IN_SNAPSHOT_EN
  logic [31:0]         snap_q, snap_d;
`endif

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    pulse_d      = stable_q & ~stable_dly_q;
    // Counter only runs while the synced level disagrees with the accepted one.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + DB_CNT_W'(1);
      end
    end

    a_d   = pulse_q[0] ? sw : a_q;
    b_d   = pulse_q[1] ? sw : b_q;
    ctl_d = pulse_q[2] ? sw[31:25] : ctl_q;

    page_d = page_q;
    if (page_q == 2'd3)  page_d = 2'd0;
    else if (pulse_q[3]) page_d = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;

`ifdef ALU_IN_SNAPSHOT_EN
    snap_d = snap_q;
    if (pulse_q[3] && page_q == 2'd1) snap_d = f_in;
`endif

    case (page_q)
      2'd0:    disp_d = a_q;
      2'd1:    disp_d = b_q;
`ifdef ALU_IN_SNAPSHOT_EN
      2'd2:    disp_d = snap_q;
`else
      2'd2:    disp_d = f_in;
`endif
      default: disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ctl_q        <= '0;
      page_q       <= '0;
      disp_q       <= '0;
`ifdef ALU_IN_SNAPSHOT_EN
      snap_q       <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      a_q          <= a_d;
      b_q          <= b_d;
      ctl_q        <= ctl_d;
      page_q       <= page_d;
      disp_q       <= disp_d;
`ifdef ALU_IN_SNAPSHOT_EN
      snap_q       <= snap_d;
`endif
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign alu_op          = ctl_q[6:3];
  assign cf              = ctl_q[2];
  assign vf              = ctl_q[1];
  assign shift_carry_out = ctl_q[0];
  assign disp_data       = disp_q;
  assign page            = page_q;
  assign btn_pulse       = pulse_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer (DB_LIMIT=4): directed plan steps plus random presses, against a behavioural reference model.
module tb_alu_input_sequencer;

  localparam int DB_LIMIT = 4;
  localparam int DB_CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic [31:0] f_in;
  logic [31:0] a_out, b_out, disp_data;
  logic [3:0]  alu_op, btn_pulse;
  logic        cf, vf, shift_carry_out;
  logic [1:0]  page;

  int n_checks = 0;
  int n_err    = 0;

  alu_input_sequencer #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .f_in(f_in),
    .a_out(a_out), .b_out(b_out), .alu_op(alu_op), .cf(cf), .vf(vf),
    .shift_carry_out(shift_carry_out), .disp_data(disp_data), .page(page),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: buttons seen two clocks late, a level is accepted after
  // DB_LIMIT consecutive disagreeing samples, a press strobes one clock after acceptance.
  bit          m_valid = 0;
  logic [3:0]  m_seen [2];
  logic [3:0]  m_level, m_level_prev, m_pulse, np;
  int          m_run [4];
  logic [31:0] m_a, m_b, m_disp, m_snap, nd;
  logic [6:0]  m_ctl;
  int          m_page, npg;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1;
      m_seen[0] = '0; m_seen[1] = '0;
      m_level = '0; m_level_prev = '0; m_pulse = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_a = '0; m_b = '0; m_ctl = '0; m_page = 0; m_disp = '0; m_snap = '0;
    end else begin
      np = m_level & ~m_level_prev;
      m_level_prev = m_level;
      for (int i = 0; i < 4; i++) begin
        if (m_seen[1][i] == m_level[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB_LIMIT) begin
            m_level[i] = m_seen[1][i];
            m_run[i] = 0;
          end
        end
      end
      m_seen[1] = m_seen[0];
      m_seen[0] = btn;
      case (m_page)
        0: nd = m_a;
        1: nd = m_b;
`ifdef ALU_IN_SNAPSHOT_EN
        2: nd = m_snap;
`else
        2: nd = f_in;
`endif
        default: nd = '0;
      endcase
      m_disp = nd;
      npg = m_page;
      if (m_pulse[3]) npg = (m_page + 1) % 3;
      if (m_pulse[3] && m_page == 1) m_snap = f_in;
      if (m_pulse[0]) m_a = sw;
      if (m_pulse[1]) m_b = sw;
      if (m_pulse[2]) m_ctl = sw[31:25];
      m_page  = npg;
      m_pulse = np;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_a_out", a_out, m_a);
      chk("m_b_out", b_out, m_b);
      chk("m_ctl", {25'd0, alu_op, cf, vf, shift_carry_out}, {25'd0, m_ctl});
      chk("m_page", {30'd0, page}, m_page);
      chk("m_disp", disp_data, m_disp);
      chk("m_pulse", {28'd0, btn_pulse}, {28'd0, m_pulse});
    end
  end

  // Raise buttons in mask, hold for `hold` clocks, run 30 clocks total.
  // exp_lat: required clocks to pulse (0 = no pulse, <0 = not checked).
  task automatic press(input logic [3:0] mask, input int hold, input int exp_lat, input bit rnd_f);
    int lat;
    lat = 0;
    btn = btn | mask;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (lat == 0 && (btn_pulse & mask) != 4'd0) lat = k;
      if (k == hold) btn = btn & ~mask;
      if (rnd_f) f_in = $urandom;
    end
    if (exp_lat >= 0) chk("press_lat", lat, exp_lat);
  endtask

  int lat;
  int exp_pg [4] = '{1, 2, 0, 1};
  int exp_dp [4] = '{2, 3, 1, 2};

  initial begin
    rst_n = 1'b0; sw = 32'hFFFF_FFFF; btn = 4'hF; f_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_ctl", {alu_op, cf, vf, shift_carry_out}, 0);
    chk("rst_disp", disp_data, 0);
    chk("rst_page", page, 0);
    chk("rst_pulse", btn_pulse, 0);

    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (btn_pulse == 4'hF) lat = k;
    end
    chk("rst_lat", lat, 7);
    btn = 4'h0;
    @(negedge clk);
    chk("rst_pulse_once", btn_pulse, 0);
    repeat (15) @(negedge clk);

    sw = 32'h1234_5678;
    press(4'h1, 10, 7, 0);
    chk("load_a", a_out, 32'h1234_5678);

    sw = 32'h0000_0000;
    press(4'h2, 3, 0, 0);
    chk("glitch_b", b_out, 32'hFFFF_FFFF);
    sw = 32'hDEAD_BEEF;
    press(4'h2, 5, 7, 0);
    chk("load_b", b_out, 32'hDEAD_BEEF);

    sw = 32'hA800_0000;
    press(4'h4, 10, 7, 0);
    chk("ctl_op", alu_op, 4'hA);
    chk("ctl_cf", cf, 1);
    chk("ctl_vf", vf, 0);
    chk("ctl_sco", shift_carry_out, 0);

    press(4'h8, 10, 7, 0);
    press(4'h8, 10, 7, 0);
    chk("page_wrap", page, 0);
    sw = 32'd1; press(4'h1, 10, 7, 0);
    sw = 32'd2; press(4'h2, 10, 7, 0);
    f_in = 32'd3;
    for (int i = 0; i < 4; i++) begin
      press(4'h8, 10, 7, 0);
      chk("cyc_page", page, exp_pg[i]);
      chk("cyc_disp", disp_data, exp_dp[i]);
    end

    press(4'h8, 10, 7, 0);
    press(4'h8, 10, 7, 0);
    sw = 32'hCAFE_F00D;
    btn = 4'h9;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (btn_pulse == 4'h9) lat = k;
    end
    chk("sim_lat", lat, 7);
    @(negedge clk);
    chk("sim_a", a_out, 32'hCAFE_F00D);
    chk("sim_page", page, 1);
    btn = 4'h0;
    repeat (20) @(negedge clk);

    f_in = 32'd5;
    press(4'h8, 10, 7, 0);
    f_in = 32'd9;
    repeat (3) @(negedge clk);
`ifdef ALU_IN_SNAPSHOT_EN
    chk("snap_disp", disp_data, 32'd5);
`else
    chk("live_disp", disp_data, 32'd9);
`endif

    sw = 32'h5555_5555;
    btn = 4'h1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    btn = 4'h0;
    repeat (15) @(negedge clk);
    chk("rst_abort_a", a_out, 0);
    chk("rst_abort_page", page, 0);

    for (int r = 0; r < 40; r++) begin
      sw = $urandom;
      press(4'($urandom_range(1, 15)), $urandom_range(1, 9), -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Front-end stage for the ALU board. It takes raw switches and push-buttons, then synchronises and debounces the buttons into single-cycle strobes.
- It latches operands A and B and the ALU control fields, and it sequences the 32-bit display page (A, B, F) fed to the 7-segment driver.
- It replaces button-edge-clocked latching with logic that is fully synchronous to clk.

Parameters:
- DB_LIMIT, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be >= 1.
- DB_CNT_W, 20, width of each debounce counter; must satisfy 2^DB_CNT_W > DB_LIMIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- sw  input  32  raw slide switches, sw[31] is the leftmost switch
- btn  input  4  raw buttons, asynchronous, active-high: [0] load A, [1] load B, [2] load control, [3] page advance
- f_in  input  32  ALU result F
- a_out  output  32  latched operand A
- b_out  output  32  latched operand B
- alu_op  output  4  latched ALU operation
- cf  output  1  latched carry-in flag
- vf  output  1  latched overflow-in flag
- shift_carry_out  output  1  latched shifter carry
- disp_data  output  32  word for the display driver
- page  output  2  current page: 0=A, 1=B, 2=F
- btn_pulse  output  4  one-cycle debounced press strobes (debug, LEDs)

Behaviour:
- Reset (rst_n low at posedge clk) clears all state: a_out, b_out, alu_op, cf, vf, shift_carry_out, disp_data, page, btn_pulse and the internal synchronisers, stable levels and counters.
- Reset asserted mid-debounce aborts the debounce with no pulse.
- Synchroniser: a 2-flop synchroniser per button feeds btn_sync.
- Debounce, per button and independent of the others:
  - Each button keeps a stable level and a counter.
  - If btn_sync == stable, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DB_LIMIT, stable <= btn_sync and the counter clears.
  - The counter never exceeds DB_LIMIT and does not wrap.
  - A glitch shorter than DB_LIMIT cycles produces no change.
- Pulse: btn_pulse[i] is high for exactly one cycle, the cycle after stable[i] goes 0->1.
  - Release (1->0) generates no pulse.
  - Holding a button produces one pulse only.
  - Press-to-pulse latency is 2 + DB_LIMIT + 1 cycles from the first high sample.
  - A button held through reset release is seen as a new press and produces one pulse after the debounce.
- Loads, using the registered btn_pulse; each takes effect in the cycle after the pulse:
  - btn_pulse[0]: a_out <= sw.
  - btn_pulse[1]: b_out <= sw.
  - btn_pulse[2]: {alu_op, cf, vf, shift_carry_out} <= sw[31:25]. alu_op = sw[31:28], cf = sw[27], vf = sw[26], shift_carry_out = sw[25]. sw[24:0] is ignored.
  - btn_pulse[3]: page advances 0->1->2->0.
- Page value 3 is unreachable. If it is ever observed, the next advance or any clock forces page to 0.
- Simultaneous pulses are all applied in the same cycle. No priority is needed because the targets are disjoint.
- disp_data is a registered mux of the current registered page:
  - page 0 gives a_out, page 1 gives b_out, page 2 gives f_in (live).
  - It lags by one cycle, so after a load or page change, disp_data is correct two cycles after the pulse.
- The switches are not synchronised. The sw value sampled in the load cycle is used, and the user is assumed static while pressing.

Optional Feature:
- Macro: ALU_IN_SNAPSHOT_EN.
- When defined, entering page 2 captures f_in into an internal snapshot register in the same cycle page becomes 2.
  - While page == 2, disp_data shows the snapshot, frozen even if A, B or the control fields change later.
  - The snapshot resets to 0.
- When undefined, page 2 shows live f_in and no snapshot register exists.

Test Plan (all with DB_LIMIT=4):
- Reset: drive rst_n=0 with sw=32'hFFFFFFFF and all btn high. All outputs must be 0. After rst_n=1, each btn_pulse bit must fire exactly once, 7 cycles after rst_n rises.
- Load A: sw=32'h12345678, btn[0] high for 10 cycles. Required: btn_pulse[0] high for 1 cycle; a_out=32'h12345678 the next cycle; disp_data=32'h12345678 one cycle later (page 0).
- Glitch reject: btn[1] high for 3 cycles, then low. Required: no btn_pulse[1] and b_out unchanged. Then btn[1] high for 5 cycles with sw=32'hDEADBEEF. Required: b_out=32'hDEADBEEF.
- Control load: sw=32'hA8000000, press btn[2]. Required: alu_op=4'hA, cf=1, vf=0, shift_carry_out=0.
- Page cycling: press btn[3] four times with a_out=1, b_out=2, f_in=3. Required: page goes 1,2,0,1 and disp_data goes 2,3,1,2.
- Simultaneous and snapshot: press btn[0] and btn[3] together on page 0. Required: a_out loads and page=1 in the same cycle. With ALU_IN_SNAPSHOT_EN: on page 2 with f_in=5, change f_in to 9. Required: disp_data stays 5.
